// File: rtl/serial_rx_if.sv
// Bundle of the serial line, its framing controls and the received-word outputs
// shared between a serial_rx and whatever drives or consumes it.
interface serial_rx_if #(
  parameter int P_DATA_WIDTH = 256
);
  // Line side: din/y0/nbits/n0/n1/cnt come from the transmitter side and timebase.
  // Word side: valid is a one-cycle strobe with no ready; the consumer must take
  // data/frame_err on that cycle or read the held values later.
  logic                    din;
  logic                    y0;
  logic [7:0]              nbits;
  logic [31:0]             n0;
  logic [31:0]             n1;
  logic [31:0]             cnt;
  logic [P_DATA_WIDTH-1:0] data;
  logic                    valid;
  logic                    frame_err;
  logic                    busy;
  logic [1:0]              dbg_state;

  modport master (
    output din, y0, nbits, n0, n1, cnt,
    input  data, valid, frame_err, busy, dbg_state
  );

  modport slave (
    input  din, y0, nbits, n0, n1, cnt,
    output data, valid, frame_err, busy, dbg_state
  );
endinterface

// File: rtl/serial_rx.sv
// Deserializer for the serial_tx line: samples din near mid-bit against the
// shared cnt timebase, MSB first, then checks the stop level against y0.
module serial_rx #(
  parameter int P_DATA_WIDTH = 256
) (
  input logic        clk,
  input logic        rst,
  serial_rx_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STOP  = 2'd2;

  logic [1:0]              state;
  logic [P_DATA_WIDTH-1:0] sr;
  logic [7:0]              bcnt;
  logic [31:0]             tgt;
  logic [31:0]             n1_l;
  logic [7:0]              nb_l;
  logic [P_DATA_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    frame_err_q;

  logic [31:0] i_n0;
  logic [31:0] i_n1;
  logic [7:0]  i_nb;
  logic [31:0] h;

  always_comb begin
    i_n0 = (bus.n0 == 32'd0)   ? 32'd1 : bus.n0;
    i_n1 = (bus.n1 == 32'd0)   ? 32'd1 : bus.n1;
    i_nb = (bus.nbits == 8'd0) ? 8'd1  : bus.nbits;
    // 33-bit sum so n1 = 2^32-1 still gives a non-zero half-bit offset.
    h    = 32'((33'(i_n1) + 33'd1) >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sr          <= '0;
      bcnt        <= 8'd0;
      tgt         <= 32'd0;
      n1_l        <= 32'd1;
      nb_l        <= 8'd1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cnt == i_n0) begin
            n1_l  <= i_n1;
            nb_l  <= i_nb;
            sr    <= '0;
            bcnt  <= 8'd0;
            tgt   <= i_n0 + h;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Equality plus an advancing target: a stalled cnt is sampled once.
          if (bus.cnt == tgt) begin
            sr   <= {sr[P_DATA_WIDTH-2:0], bus.din};
            bcnt <= bcnt + 8'd1;
            tgt  <= tgt + n1_l;
            if (bcnt == nb_l - 8'd1) begin
              state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (bus.cnt == tgt) begin
            data_q      <= sr;
            valid_q     <= 1'b1;
            frame_err_q <= (bus.din != bus.y0);
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state == S_SHIFT) || (state == S_STOP);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: a 256-bit and a 16-bit receiver share one line driven
// by a behavioural serial_tx model; table vectors, corner sequences, random frames.
module tb_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        y0;
  logic [7:0]  nbits;
  logic [31:0] n0;
  logic [31:0] n1;
  logic [31:0] cnt;

  serial_rx_if #(.P_DATA_WIDTH(256)) bus_n ();
  serial_rx_if #(.P_DATA_WIDTH(16))  bus_w ();

  assign bus_n.din = din;   assign bus_w.din = din;
  assign bus_n.y0 = y0;     assign bus_w.y0 = y0;
  assign bus_n.nbits = nbits; assign bus_w.nbits = nbits;
  assign bus_n.n0 = n0;     assign bus_w.n0 = n0;
  assign bus_n.n1 = n1;     assign bus_w.n1 = n1;
  assign bus_n.cnt = cnt;   assign bus_w.cnt = cnt;

  serial_rx #(.P_DATA_WIDTH(256)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));
  serial_rx #(.P_DATA_WIDTH(16))  dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n0;
    logic [31:0] n1;
    logic [7:0]  nbits;
    logic [63:0] txd;
    logic        y0;
    bit          stop_err;
    int          rst_at;
    logic [7:0]  nb_late;
    int          end_cnt;
    bit          exp_valid;
    logic [63:0] exp_data;
    logic [63:0] exp_data_w;
    logic        exp_err;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [255:0] exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] vn0, input logic [31:0] vn1, input logic [7:0] vnb,
                              input logic [63:0] vtxd, input logic vy0, input bit verr,
                              input int vrst, input logic [7:0] vlate, input int vend,
                              input bit vexp, input logic [63:0] ed, input logic [63:0] edw,
                              input logic ee);
    vec_t v;
    v.n0 = vn0; v.n1 = vn1; v.nbits = vnb; v.txd = vtxd; v.y0 = vy0; v.stop_err = verr;
    v.rst_at = vrst; v.nb_late = vlate; v.end_cnt = vend; v.exp_valid = vexp;
    v.exp_data = ed; v.exp_data_w = edw; v.exp_err = ee;
    return v;
  endfunction

  // serial_tx line model: bit k (MSB first) occupies cnt n0+k*n1+1 .. n0+(k+1)*n1.
  function automatic logic line_bit(input int c, input int n0i, input int n1i, input int nbi,
                                    input logic [63:0] txd, input logic yv);
    int k;
    if (c > n0i && c <= n0i + nbi * n1i) begin
      k = (c - n0i - 1) / n1i;
      return txd[nbi - 1 - k];
    end
    return yv;
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int n0i, n1i, nbi, h, stop, last;
    int vc_n, vc_w, vat;
    logic [255:0] d_n;
    logic         e_n, e_w;
    logic [15:0]  d_w;
    n0i = (v.n0 == 0) ? 1 : int'(v.n0);
    n1i = (v.n1 == 0) ? 1 : int'(v.n1);
    nbi = (v.nbits == 0) ? 1 : int'(v.nbits);
    h = (n1i + 1) / 2;
    stop = n0i + nbi * n1i + h;
    last = (v.end_cnt > stop + 2) ? v.end_cnt : stop + 2;
    vc_n = 0; vc_w = 0; vat = -1; d_n = '0; e_n = 1'b0; d_w = '0; e_w = 1'b0;
    if (v.exp_valid) exp_q.push_back(256'(v.exp_data));
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (bus_n.valid) begin
          vc_n++;
          vat = c - 1;
          d_n = bus_n.data;
          e_n = bus_n.frame_err;
          if (exp_q.size() > 0) check({tag, " data"}, d_n, exp_q.pop_front());
          else check({tag, " valid with nothing expected"}, 1, 0);
        end
        if (bus_w.valid) begin
          vc_w++;
          d_w = bus_w.data;
          e_w = bus_w.frame_err;
        end
        if (v.exp_valid && (c - 1) == n0i) check({tag, " busy after start"}, bus_n.busy, 1);
        if (v.exp_valid && (c - 1) == stop) check({tag, " busy after stop"}, bus_n.busy, 0);
      end
      if (c <= last) begin
        cnt = 32'(c);
        n0 = v.n0;
        n1 = v.n1;
        y0 = v.y0;
        nbits = (v.nb_late != 0 && c >= 20) ? v.nb_late : v.nbits;
        din = line_bit(c, n0i, n1i, nbi, v.txd, v.y0);
        if (c == stop && v.stop_err) din = ~v.y0;
        rst = (c == v.rst_at);
      end
    end
    rst = 1'b0;
    if (v.exp_valid) begin
      check({tag, " valid count"}, vc_n, 1);
      check({tag, " valid cnt"}, vat, stop);
      check({tag, " frame_err"}, e_n, v.exp_err);
      check({tag, " wide valid count"}, vc_w, 1);
      check({tag, " wide data"}, d_w, v.exp_data_w[15:0]);
      check({tag, " wide frame_err"}, e_w, v.exp_err);
      check({tag, " data hold"}, bus_n.data, 256'(v.exp_data));
      check({tag, " frame_err hold"}, bus_n.frame_err, v.exp_err);
    end else begin
      check({tag, " valid count"}, vc_n, 0);
      check({tag, " wide valid count"}, vc_w, 0);
      check({tag, " data cleared"}, bus_n.data, 0);
      check({tag, " frame_err cleared"}, bus_n.frame_err, 0);
      check({tag, " busy"}, bus_n.busy, 0);
      check({tag, " wide data cleared"}, bus_w.data, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    vec_t rv;
    int nbr;
    rst = 1'b1; din = 1'b1; y0 = 1'b1; nbits = 8'd0; n0 = 32'd0; n1 = 32'd0; cnt = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data", bus_n.data, 0);
    check("reset valid", bus_n.valid, 0);
    check("reset frame_err", bus_n.frame_err, 0);
    check("reset busy", bus_n.busy, 0);
    check("reset state", bus_n.dbg_state, 0);
    rst = 1'b0;

    vecs[0] = mk(10, 4, 8,  64'hA5,    1, 0, -1,  0, 0,  1, 64'hA5,    64'hA5,   0);
    vecs[1] = mk(10, 4, 8,  64'hA5,    1, 1, -1,  0, 0,  1, 64'hA5,    64'hA5,   1);
    vecs[2] = mk(0,  0, 0,  64'h1,     0, 0, -1,  0, 0,  1, 64'h1,     64'h1,    0);
    vecs[3] = mk(10, 4, 8,  64'hA5,    1, 0, 20,  0, 0,  0, 64'h0,     64'h0,    0);
    vecs[4] = mk(10, 4, 8,  64'hA5,    1, 0, -1,  0, 0,  1, 64'hA5,    64'hA5,   0);
    vecs[5] = mk(10, 4, 8,  64'hA5,    1, 0, -1,  4, 60, 1, 64'hA5,    64'hA5,   0);
    // Second back-to-back frame: tx puts the top nibble of 0x3C on a 4-bit frame.
    vecs[6] = mk(10, 4, 4,  64'h3C >> 4, 1, 0, -1, 0, 60, 1, 64'h3,     64'h3,    0);
    vecs[7] = mk(10, 4, 20, 64'hABCDE, 1, 0, -1,  0, 0,  1, 64'hABCDE, 64'hBCDE, 0);
    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      rv = mk(32'($urandom_range(0, 20)), 32'($urandom_range(0, 6)), 8'($urandom_range(0, 24)),
              {32'd0, $urandom()}, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              -1, 0, 0, 1, 0, 0, 0);
      nbr = (rv.nbits == 0) ? 1 : int'(rv.nbits);
      rv.exp_data = rv.txd & ((64'd1 << nbr) - 64'd1);
      rv.exp_data_w = rv.exp_data & 64'hFFFF;
      rv.exp_err = rv.stop_err;
      run_frame(rv, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
